// File: rtl/l4_pkg.sv
// Shared constants and types for the layer-4 accumulator and its RAM.
// The RAM is 64 words of 36 bits, accessed as four 16-lane groups.
package l4_pkg;

  localparam int L4_WORDS  = 64;
  localparam int L4_LANES  = 16;
  localparam int L4_DATA_W = 36;
  localparam int L4_GROUPS = L4_WORDS / L4_LANES;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN
  } acc_state_e;

  typedef logic signed [L4_DATA_W-1:0] word_t;

endpackage

// File: rtl/l4_acc_lane.sv
// One accumulator lane: (first_pass ? 0 : cur) + psum, signed.
// L4_ACC_SAT_EN selects clamping to the signed DATA_W range and adds a sat output.
module l4_acc_lane
  import l4_pkg::*;
#(
  parameter int DATA_W = L4_DATA_W
) (
  input  logic              first_pass,
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] psum,
  output logic [DATA_W-1:0] sum
`ifdef L4_ACC_SAT_EN
  ,
  output logic              sat
`endif
);

  logic [DATA_W-1:0] base;

  // The first pass discards whatever stale data the RAM holds.
  assign base = first_pass ? '0 : cur;

`ifdef L4_ACC_SAT_EN
  logic [DATA_W:0] wide;

  assign wide = {base[DATA_W-1], base} + {psum[DATA_W-1], psum};
  // Sign bit of the extended sum disagreeing with bit DATA_W-1 means overflow.
  assign sat  = wide[DATA_W] ^ wide[DATA_W-1];

  always_comb begin
    sum = wide[DATA_W-1:0];
    if (sat) begin
      sum = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign sum = base + psum;
`endif

endmodule

// File: rtl/l4_acc.sv
// Read-modify-write accumulator for the 64x36 layer-4 RAM: one 16-lane group per beat,
// GROUPS beats per pass, NUM_PASSES passes, then a one-cycle done. Optional L4_ACC_SAT_EN.
module l4_acc
  import l4_pkg::*;
#(
  parameter int NUM_PASSES = 25,
  parameter int DATA_W     = L4_DATA_W,
  parameter int GROUPS     = L4_GROUPS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [L4_LANES-1:0][DATA_W-1:0]  psum,
  input  logic [L4_LANES-1:0][DATA_W-1:0]  dout_wr,
  output logic                             wr,
  output logic [$clog2(L4_WORDS)-1:0]      addr_wr,
  output logic [L4_LANES-1:0][DATA_W-1:0]  din,
  output logic                             busy,
  output logic                             done
`ifdef L4_ACC_SAT_EN
  ,
  output logic                             sat_flag
`endif
);

  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int ADDR_W = $clog2(L4_WORDS);
  localparam int LANE_SH = $clog2(L4_LANES);

  acc_state_e state, state_nxt;
  logic [GRP_W-1:0]  grp;
  logic [PASS_W-1:0] pass;
  logic              last_grp;
  logic              last_pass;
  logic              first_pass;
  logic [GRP_W-1:0]  grp_inc;
  logic [L4_LANES-1:0][DATA_W-1:0] lane_sum;
`ifdef L4_ACC_SAT_EN
  logic [L4_LANES-1:0] lane_sat;
`endif

  assign last_grp   = (grp == GRP_W'(GROUPS - 1));
  assign last_pass  = (pass == PASS_W'(NUM_PASSES - 1));
  assign first_pass = (pass == '0);
  assign grp_inc    = grp + 1'b1;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr        = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        wr       = in_valid;
        if (in_valid && last_grp && last_pass) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grp     <= '0;
      pass    <= '0;
      addr_wr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        grp     <= '0;
        pass    <= '0;
        addr_wr <= '0;
      end else if (wr) begin
        if (last_grp) begin
          grp     <= '0;
          addr_wr <= '0;
          pass    <= last_pass ? '0 : pass + 1'b1;
        end else begin
          grp     <= grp_inc;
          addr_wr <= ADDR_W'(grp_inc) << LANE_SH;
        end
      end
    end
  end

`ifdef L4_ACC_SAT_EN
  // Sticky across the run so it can be read after done; cleared by the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (state == IDLE && start) begin
      sat_flag <= 1'b0;
    end else if (wr && |lane_sat) begin
      sat_flag <= 1'b1;
    end
  end
`endif

  for (genvar j = 0; j < L4_LANES; j++) begin : g_lane
    l4_acc_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .first_pass(first_pass),
      .cur       (dout_wr[j]),
      .psum      (psum[j]),
      .sum       (lane_sum[j])
`ifdef L4_ACC_SAT_EN
      ,
      .sat       (lane_sat[j])
`endif
    );

    assign din[j] = (state == ACC) ? lane_sum[j] : '0;
  end

endmodule
